// File: rtl/cv32e40p_apu_disp_nb.sv
// Non-blocking APU dispatcher: tracks up to DEPTH in-order outstanding
// multicycle ops, flags RAW/WAW hazards and returns writeback addresses.
//
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i,
// apu_lat_i, apu_waddr_i issue request from ID; apu_req_o/apu_gnt_i
// interconnect handshake; apu_rvalid_i result return; apu_waddr_o,
// apu_wvalid_o writeback; apu_multicycle_o, apu_singlecycle_o, active_o,
// count_o status; stall_o and perf_* stall causes; is_decoding_i,
// read_regs_i/read_regs_valid_i, write_regs_i/write_regs_valid_i
// dependency queries with read_dep_o/write_dep_o; err_o sticky error.
module cv32e40p_apu_disp_nb #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [1:0]             apu_lat_i,
  input  logic [ADDR_W-1:0]      apu_waddr_i,
  output logic                   apu_req_o,
  input  logic                   apu_gnt_i,
  input  logic                   apu_rvalid_i,
  output logic [ADDR_W-1:0]      apu_waddr_o,
  output logic                   apu_wvalid_o,
  output logic                   apu_multicycle_o,
  output logic                   apu_singlecycle_o,
  output logic                   active_o,
  output logic [CW-1:0]          count_o,
  output logic                   stall_o,
  input  logic                   is_decoding_i,
  input  logic [N_RD*ADDR_W-1:0] read_regs_i,
  input  logic [N_RD-1:0]        read_regs_valid_i,
  output logic                   read_dep_o,
  input  logic [N_WR*ADDR_W-1:0] write_regs_i,
  input  logic [N_WR-1:0]        write_regs_valid_i,
  output logic                   write_dep_o,
  output logic                   perf_type_o,
  output logic                   perf_cont_o,
  output logic                   perf_full_o,
  output logic                   err_o
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        stored_lat;
  logic              err;

  logic active;
  logic stall_full;
  logic stall_type;
  logic stall_nack;
  logic valid_req;
  logic pop;
  logic same;
  logic push;
  logic err_set;

  assign active     = (count != '0);
  assign stall_full = (count == CW'(DEPTH));
  assign stall_type = enable_i & active &
                      ((apu_lat_i == 2'd1) |
                       (apu_lat_i == 2'd3) |
                       ((apu_lat_i == 2'd2) &
                        (stored_lat == 2'd3)));
  assign valid_req  = enable_i & ~stall_full & ~stall_type;
  assign stall_nack = valid_req & ~apu_gnt_i;

  // A result with nothing queued belongs to the op issuing now.
  assign pop     = apu_rvalid_i & active;
  assign same    = apu_rvalid_i & ~active & valid_req;
  assign err_set = apu_rvalid_i & ~active & ~valid_req;
  assign push    = valid_req & apu_gnt_i & ~same;

  assign apu_req_o         = valid_req;
  assign stall_o           = stall_full | stall_type | stall_nack;
  assign perf_type_o       = stall_type;
  assign perf_cont_o       = stall_nack;
  assign perf_full_o       = stall_full;
  assign active_o          = active;
  assign apu_singlecycle_o = ~active;
  assign apu_multicycle_o  = (stored_lat == 2'd3);
  assign count_o           = count;
  assign err_o             = err;
  assign apu_wvalid_o      = pop | same;

  always_comb begin
    apu_waddr_o = '0;
    if (pop)       apu_waddr_o = mem[rd_ptr];
    else if (same) apu_waddr_o = apu_waddr_i;
  end

  logic          rd_hit;
  logic          wr_hit;
  logic          live;
  logic [PW-1:0] idx;

  // The head entry retiring this cycle no longer blocks anything.
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    live   = 1'b0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = rd_ptr + PW'(k);
      live = (CW'(k) < count) && !(pop && (k == 0));
      for (int r = 0; r < N_RD; r++)
        if (live && read_regs_valid_i[r] &&
            read_regs_i[r*ADDR_W +: ADDR_W] == mem[idx])
          rd_hit = 1'b1;
      for (int w = 0; w < N_WR; w++)
        if (live && write_regs_valid_i[w] &&
            write_regs_i[w*ADDR_W +: ADDR_W] == mem[idx])
          wr_hit = 1'b1;
    end
    if (valid_req && !same) begin
      for (int r = 0; r < N_RD; r++)
        if (read_regs_valid_i[r] &&
            read_regs_i[r*ADDR_W +: ADDR_W] == apu_waddr_i)
          rd_hit = 1'b1;
      for (int w = 0; w < N_WR; w++)
        if (write_regs_valid_i[w] &&
            write_regs_i[w*ADDR_W +: ADDR_W] == apu_waddr_i)
          wr_hit = 1'b1;
    end
  end

  assign read_dep_o  = is_decoding_i & rd_hit;
  assign write_dep_o = is_decoding_i & wr_hit;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= apu_waddr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stored_lat <= 2'd0;
      err        <= 1'b0;
    end else begin
      if (valid_req) stored_lat <= apu_lat_i;
      if (push)      wr_ptr     <= wr_ptr + 1'b1;
      if (pop)       rd_ptr     <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (err_set)   err        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_disp_nb.sv
// Scoreboard bench for cv32e40p_apu_disp_nb: expected writeback
// addresses queue up at grant and are checked on return.
module tb_cv32e40p_apu_disp_nb;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    lat;
  logic [AW-1:0] waddr_in;
  logic          req;
  logic          gnt;
  logic          rvalid;
  logic [AW-1:0] waddr_out;
  logic          wvalid;
  logic          multi;
  logic          single;
  logic          active;
  logic [2:0]    count;
  logic          stall;
  logic          decoding;
  logic [3*AW-1:0] rregs;
  logic [2:0]    rvld;
  logic          rdep;
  logic [2*AW-1:0] wregs;
  logic [1:0]    wvld;
  logic          wdep;
  logic          ptype;
  logic          pcont;
  logic          pfull;
  logic          err;

  int nvec = 0;
  int nerr = 0;
  logic [AW-1:0] sb [$];
  logic [AW-1:0] exp_a;

  always #5 clk = ~clk;

  cv32e40p_apu_disp_nb dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .enable_i           (enable),
    .apu_lat_i          (lat),
    .apu_waddr_i        (waddr_in),
    .apu_req_o          (req),
    .apu_gnt_i          (gnt),
    .apu_rvalid_i       (rvalid),
    .apu_waddr_o        (waddr_out),
    .apu_wvalid_o       (wvalid),
    .apu_multicycle_o   (multi),
    .apu_singlecycle_o  (single),
    .active_o           (active),
    .count_o            (count),
    .stall_o            (stall),
    .is_decoding_i      (decoding),
    .read_regs_i        (rregs),
    .read_regs_valid_i  (rvld),
    .read_dep_o         (rdep),
    .write_regs_i       (wregs),
    .write_regs_valid_i (wvld),
    .write_dep_o        (wdep),
    .perf_type_o        (ptype),
    .perf_cont_o        (pcont),
    .perf_full_o        (pfull),
    .err_o              (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable   = 1'b0;
    lat      = 2'd0;
    waddr_in = '0;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    decoding = 1'b0;
    rregs    = '0;
    rvld     = '0;
    wregs    = '0;
    wvld     = '0;
  endtask

  task automatic issue(input logic [1:0] l,
                       input logic [AW-1:0] a);
    idle();
    enable   = 1'b1;
    lat      = l;
    waddr_in = a;
    gnt      = 1'b1;
    @(negedge clk);
    nvec++;
    if (req !== 1'b1 || stall !== 1'b0) begin
      nerr++;
      $display("FAIL issue a=%0d req=%b stall=%b want 1/0",
               a, req, stall);
    end
    sb.push_back(a);
    tick();
    idle();
  endtask

  task automatic retire();
    idle();
    rvalid = 1'b1;
    @(negedge clk);
    exp_a = sb.pop_front();
    nvec++;
    if (wvalid !== 1'b1 || waddr_out !== exp_a) begin
      nerr++;
      $display("FAIL retire wvalid=%b waddr=%0d want 1/%0d",
               wvalid, waddr_out, exp_a);
    end
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    nvec++;
    if ({req, wvalid, waddr_out, count, single, active,
         multi, err, stall, rdep, wdep, ptype, pcont, pfull}
        !== {2'b00, 6'd0, 3'd0, 1'b1, 9'd0}) begin
      nerr++;
      $display("FAIL reset req=%b wv=%b wa=%0d cnt=%0d sc=%b act=%b err=%b",
               req, wvalid, waddr_out, count, single, active, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    idle();
    enable = 1'b1; lat = 2'd2; waddr_in = 6'd5;
    gnt = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    nvec++;
    if (wvalid !== 1'b1 || waddr_out !== 6'd5) begin
      nerr++;
      $display("FAIL same_cycle wv=%b wa=%0d want 1/5",
               wvalid, waddr_out);
    end
    tick();
    idle();
    @(negedge clk);
    nvec++;
    if (count !== 3'd0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL same_cycle_cnt cnt=%0d err=%b want 0/0",
               count, err);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) issue(2'd2, AW'(i));
    enable = 1'b1; lat = 2'd2; waddr_in = 6'd9; gnt = 1'b1;
    @(negedge clk);
    nvec++;
    if (count !== 3'd4 || stall !== 1'b1 ||
        pfull !== 1'b1 || req !== 1'b0) begin
      nerr++;
      $display("FAIL full cnt=%0d stall=%b full=%b req=%b want 4/1/1/0",
               count, stall, pfull, req);
    end
    tick();
    idle();
    for (int i = 0; i < 4; i++) retire();
    @(negedge clk);
    nvec++;
    if (count !== 3'd0 || single !== 1'b1) begin
      nerr++;
      $display("FAIL drain cnt=%0d sc=%b want 0/1", count, single);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) issue(2'd2, AW'(10 + i));
    retire();
    for (int i = 0; i < 5; i++) begin
      idle();
      rvalid = 1'b1; enable = 1'b1; lat = 2'd2;
      waddr_in = AW'(20 + i); gnt = 1'b1;
      @(negedge clk);
      exp_a = sb.pop_front();
      sb.push_back(AW'(20 + i));
      nvec++;
      if (waddr_out !== exp_a || req !== 1'b1 || count !== 3'd3) begin
        nerr++;
        $display("FAIL b2b%0d wa=%0d req=%b cnt=%0d want %0d/1/3",
                 i, waddr_out, req, count, exp_a);
      end
      tick();
    end
    idle();
    while (sb.size() != 0) retire();
  endtask

  task automatic test_deps();
    issue(2'd3, 6'd7);
    decoding = 1'b1;
    rregs = {6'd0, 6'd7, 6'd0}; rvld = 3'b010;
    wregs = {6'd0, 6'd7};       wvld = 2'b01;
    @(negedge clk);
    nvec++;
    if (rdep !== 1'b1 || wdep !== 1'b1 || multi !== 1'b1) begin
      nerr++;
      $display("FAIL dep_hold rdep=%b wdep=%b mc=%b want 1/1/1",
               rdep, wdep, multi);
    end
    enable = 1'b1; lat = 2'd2; waddr_in = 6'd8; gnt = 1'b1;
    #1;
    nvec++;
    if (ptype !== 1'b1 || stall !== 1'b1 || req !== 1'b0) begin
      nerr++;
      $display("FAIL dep_type type=%b stall=%b req=%b want 1/1/0",
               ptype, stall, req);
    end
    rvalid = 1'b1;
    #1;
    exp_a = sb.pop_front();
    nvec++;
    if (rdep !== 1'b0 || wdep !== 1'b0 || waddr_out !== exp_a) begin
      nerr++;
      $display("FAIL dep_pop rdep=%b wdep=%b wa=%0d want 0/0/%0d",
               rdep, wdep, waddr_out, exp_a);
    end
    tick();
    idle();
    decoding = 1'b1;
    rregs = {6'd7, 6'd0, 6'd0}; rvld = 3'b100;
    enable = 1'b1; lat = 2'd0; waddr_in = 6'd7; gnt = 1'b1;
    @(negedge clk);
    nvec++;
    if (rdep !== 1'b1 || req !== 1'b1) begin
      nerr++;
      $display("FAIL dep_issue rdep=%b req=%b want 1/1", rdep, req);
    end
    sb.push_back(6'd7);
    tick();
    idle();
    retire();
  endtask

  task automatic test_nack();
    idle();
    enable = 1'b1; lat = 2'd2; waddr_in = 6'd33; gnt = 1'b0;
    @(negedge clk);
    nvec++;
    if (stall !== 1'b1 || pcont !== 1'b1 || req !== 1'b1) begin
      nerr++;
      $display("FAIL nack stall=%b cont=%b req=%b want 1/1/1",
               stall, pcont, req);
    end
    tick();
    nvec++;
    if (count !== 3'd0) begin
      nerr++;
      $display("FAIL nack_cnt cnt=%0d want 0", count);
    end
    gnt = 1'b1;
    @(negedge clk);
    sb.push_back(6'd33);
    tick();
    idle();
    nvec++;
    if (count !== 3'd1) begin
      nerr++;
      $display("FAIL nack_push cnt=%0d want 1", count);
    end
    retire();
  endtask

  task automatic test_err_reset();
    idle();
    rvalid = 1'b1;
    tick();
    idle();
    tick();
    nvec++;
    if (err !== 1'b1 || count !== 3'd0) begin
      nerr++;
      $display("FAIL err_sticky err=%b cnt=%0d want 1/0", err, count);
    end
    issue(2'd3, 6'd3);
    issue(2'd0, 6'd4);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    nvec++;
    if (count !== 3'd0 || err !== 1'b0 || single !== 1'b1 ||
        active !== 1'b0 || multi !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset cnt=%0d err=%b sc=%b act=%b mc=%b",
               count, err, single, active, multi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rvalid = 1'b1;
    @(negedge clk);
    nvec++;
    if (wvalid !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset_wv wv=%b want 0", wvalid);
    end
    tick();
    idle();
    nvec++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_err err=%b want 1", err);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #3;
    test_reset();
    test_same_cycle();
    test_fill();
    test_back_to_back();
    test_deps();
    test_nack();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
